// File: rtl/instruction_fetch.sv
// Front pipeline stage: drives the PC, buffers imem words in a 4-entry FIFO and
// issues one 1- or 2-word instruction per cycle, inserting NOP bubbles as needed.
module instruction_fetch #(
   parameter int unsigned           ADDR_WIDTH   = 32,
   parameter int unsigned           WORD_WIDTH   = 16,
   parameter int unsigned           OPCODE_WIDTH = 6,
   parameter logic [63:0]           LONG_OP_MASK = 64'h0,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
   input  logic                    gclk,
   input  logic                    grst_n,
   input  logic                    stall,
   input  logic                    JumpFlag,
   input  logic                    JumpType,
   input  logic                    JumpAddrSign,
   input  logic [ADDR_WIDTH-1:0]   JumpAddr,
   output logic                    imem_req,
   output logic [ADDR_WIDTH-1:0]   imem_addr,
   input  logic [WORD_WIDTH-1:0]   imem_rdata,
   input  logic                    imem_valid,
   output logic [2*WORD_WIDTH-1:0] OutDataBus,
   output logic [ADDR_WIDTH-1:0]   OutPc
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [WORD_WIDTH-1:0]   buf_word [4];
   logic [ADDR_WIDTH-1:0]   buf_addr [4];
   logic [1:0]              rd_ptr, wr_ptr, rd_ptr1;
   logic [2:0]              count, credit_used;
   logic [1:0]              outstanding, outstanding_nxt, discard;
   logic [ADDR_WIDTH-1:0]   fetch_pc, push_pc, out_pc, target;
   logic [2*WORD_WIDTH-1:0] out_data;
   logic                    rst_seen;
   logic [OPCODE_WIDTH-1:0] head_op;
   logic                    head_long, push, jump;
   logic [1:0]              pop_n;

   // Credit covers buffered words plus words still in flight, so a push never overflows.
   assign credit_used     = count + {1'b0, outstanding};
   assign imem_req        = rst_seen && (credit_used < 3'd4) && (outstanding < 2'd2);
   assign imem_addr       = fetch_pc;
   assign outstanding_nxt = outstanding + {1'b0, imem_req} - {1'b0, imem_valid};

   assign rd_ptr1   = rd_ptr + 2'd1;
   assign head_op   = buf_word[rd_ptr][OPCODE_WIDTH-1:0];
   assign head_long = LONG_OP_MASK[head_op];
   assign jump      = JumpFlag && !stall;
   assign push      = imem_valid && (discard == 2'd0) && !jump;

   always_comb begin
      pop_n = 2'd0;
      if (!stall && !jump) begin
         if (count >= 3'd2)
            pop_n = head_long ? 2'd2 : 2'd1;
         else if (count == 3'd1 && !head_long)
            pop_n = 2'd1;
      end
   end

   always_comb begin
      if (JumpType)
         target = JumpAddr;
      else if (JumpAddrSign)
         target = out_pc - JumpAddr;
      else
         target = out_pc + JumpAddr;
   end

   always_ff @(posedge gclk) begin
      if (push) begin
         buf_word[wr_ptr] <= imem_rdata;
         buf_addr[wr_ptr] <= push_pc;
      end
   end

   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         rst_seen    <= 1'b0;
         fetch_pc    <= RESET_PC;
         push_pc     <= RESET_PC;
         rd_ptr      <= 2'd0;
         wr_ptr      <= 2'd0;
         count       <= 3'd0;
         outstanding <= 2'd0;
         discard     <= 2'd0;
         out_data    <= '0;
         out_pc      <= '0;
      end else begin
         rst_seen    <= 1'b1;
         outstanding <= outstanding_nxt;
         if (jump) begin
            // Every word still in flight belongs to the old stream and must be dropped.
            fetch_pc <= target;
            push_pc  <= target;
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            count    <= 3'd0;
            discard  <= outstanding_nxt;
            out_data <= '0;
         end else begin
            if (imem_req)
               fetch_pc <= fetch_pc + ADDR_ONE;
            if (imem_valid && discard != 2'd0)
               discard <= discard - 2'd1;
            if (push) begin
               wr_ptr  <= wr_ptr + 2'd1;
               push_pc <= push_pc + ADDR_ONE;
            end
            rd_ptr <= rd_ptr + pop_n;
            count  <= count + {2'b00, push} - {1'b0, pop_n};
            if (!stall) begin
               case (pop_n)
                  2'd1: begin
                     out_data <= {{WORD_WIDTH{1'b0}}, buf_word[rd_ptr]};
                     out_pc   <= buf_addr[rd_ptr];
                  end
                  2'd2: begin
                     out_data <= {buf_word[rd_ptr1], buf_word[rd_ptr]};
                     out_pc   <= buf_addr[rd_ptr];
                  end
                  default: out_data <= '0;
               endcase
            end
         end
      end
   end

   assign OutDataBus = out_data;
   assign OutPc      = out_pc;

   a_no_overflow: assert property (@(posedge gclk) disable iff (!grst_n)
      !(push && count == 3'd4 && pop_n == 2'd0));

endmodule
